// File: rtl/ch_adv_parser_pkg.sv
// Shared constants, types and helpers for the CH advertisement parser.
package ch_adv_parser_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int MEM_WIDTH  = 8;
  localparam int MEM_DEPTH  = 2048;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);

  // Packet type codes carried in byte 0
  localparam logic [MEM_WIDTH-1:0] TYPE_HB    = 8'h01;
  localparam logic [MEM_WIDTH-1:0] TYPE_CHADV = 8'h02;

  // Byte offsets of the fields inside a packet (16-bit fields are big-endian)
  localparam int OFS_TYPE   = 0;
  localparam int OFS_SRC_ID = 1;
  localparam int OFS_HOPS   = 3;  // CH limit for heartbeat packets
  localparam int OFS_QVALUE = 5;
  localparam int PKT_BYTES  = 7;

  // Word index of each 16-bit field once bytes 1..6 are paired up
  localparam logic [1:0] WORD_SRC_ID = 2'((OFS_SRC_ID - 1) / 2);
  localparam logic [1:0] WORD_HOPS   = 2'((OFS_HOPS - 1) / 2);
  localparam logic [1:0] WORD_QVALUE = 2'((OFS_QVALUE - 1) / 2);

  // A hops value of all-ones marks an unreachable cluster head
  localparam logic [WORD_WIDTH-1:0] HOPS_INVALID = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_EMIT,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    PKT_UNKNOWN,
    PKT_HB,
    PKT_CHADV
  } pkt_kind_t;

  // Classify the type byte
  function automatic pkt_kind_t decode_type(input logic [MEM_WIDTH-1:0] type_byte);
    if (type_byte == TYPE_HB) begin
      return PKT_HB;
    end else if (type_byte == TYPE_CHADV) begin
      return PKT_CHADV;
    end
    return PKT_UNKNOWN;
  endfunction

  // Hop count seen by the receiver: one more than advertised, never wrapping
  function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
    return (v == HOPS_INVALID) ? v : v + WORD_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ch_adv_parser_if.sv
// Packet-memory, control and result bundle of the CH advertisement parser.
interface ch_adv_parser_if;
  import ch_adv_parser_pkg::*;

  logic                  pkt_start;
  logic [ADDR_WIDTH-1:0] pkt_base;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  mem_rdata;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  en_KCH;
  logic [WORD_WIDTH-1:0] fCH_ID;
  logic [WORD_WIDTH-1:0] fCH_Hops;
  logic [WORD_WIDTH-1:0] fCH_QValue;
  logic                  HB_reset;
  logic [WORD_WIDTH-1:0] HB_CHlimit;

  // Parser side
  modport slave (
    input  pkt_start, pkt_base, mem_rdata,
    output mem_addr, busy, done, err, en_KCH,
           fCH_ID, fCH_Hops, fCH_QValue, HB_reset, HB_CHlimit
  );

  // Requester / memory side
  modport master (
    output pkt_start, pkt_base, mem_rdata,
    input  mem_addr, busy, done, err, en_KCH,
           fCH_ID, fCH_Hops, fCH_QValue, HB_reset, HB_CHlimit
  );

endinterface

// File: rtl/pkt_word_asm.sv
// Pairs consecutive packet bytes into big-endian 16-bit words.
// The word is presented combinationally in the cycle its low byte arrives,
// so the caller can act on the final field without an extra cycle.
module pkt_word_asm
  import ch_adv_parser_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [MEM_WIDTH-1:0]  byte_in,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word,
  output logic [1:0]            word_idx
);

  logic [MEM_WIDTH-1:0] hi_q;
  logic                 have_hi;
  logic [1:0]           idx_q;

  // Hold the high byte and count completed words
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (nrst || clear) begin
      hi_q    <= '0;
      have_hi <= 1'b0;
      idx_q   <= '0;
    end else if (byte_valid) begin
      if (!have_hi) begin
        hi_q    <= byte_in;
        have_hi <= 1'b1;
      end else begin
        have_hi <= 1'b0;
        idx_q   <= idx_q + 2'd1;
      end
    end
  end

  assign word_valid = byte_valid && have_hi;
  assign word       = {hi_q, byte_in};
  assign word_idx   = idx_q;

endmodule

// File: rtl/ch_adv_parser.sv
// Reads a 7-byte packet from the packet memory and decodes it as a CH
// advertisement or a heartbeat. Unknown types abort right after byte 0.
// A cycle counter (1 = first cycle after start accepted) drives the
// fixed read schedule: address k goes out in counter cycle k+1 and its
// data is on mem_rdata in counter cycle k+2.
module ch_adv_parser
  import ch_adv_parser_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  ch_adv_parser_if.slave  bus
);

  // Counter cycle in which byte 0 sits on mem_rdata
  localparam logic [3:0] CYC_TYPE        = 4'(OFS_TYPE + 2);
  // Counter cycle in which byte 1 (first field byte) sits on mem_rdata
  localparam logic [3:0] CYC_FIRST_FIELD = 4'(OFS_SRC_ID + 2);
  // Last counter cycle that issues a new address (for byte PKT_BYTES-1)
  localparam logic [3:0] CYC_LAST_ADDR   = 4'(PKT_BYTES - 1);

  state_t                state;
  pkt_kind_t             kind_q;
  logic [3:0]            cyc;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [WORD_WIDTH-1:0] src_id_q;
  logic [WORD_WIDTH-1:0] mid_q;     // hops (CHADV) or CH limit (HB)

  logic                  asm_clear;
  logic                  byte_valid;
  logic                  word_valid;
  logic [WORD_WIDTH-1:0] word;
  logic [1:0]            word_idx;
  pkt_kind_t             rx_kind;

  assign asm_clear  = (state == ST_IDLE);
  assign byte_valid = (state == ST_READ) && (cyc >= CYC_FIRST_FIELD);
  assign rx_kind    = decode_type(bus.mem_rdata);

  pkt_word_asm u_word_asm (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (asm_clear),
    .byte_valid (byte_valid),
    .byte_in    (bus.mem_rdata),
    .word_valid (word_valid),
    .word       (word),
    .word_idx   (word_idx)
  );

  // Parser FSM with registered address, status pulses and result fields
  always_ff @(posedge clk) begin
    if (nrst) begin
      state          <= ST_IDLE;
      kind_q         <= PKT_UNKNOWN;
      cyc            <= '0;
      base_q         <= '0;
      src_id_q       <= '0;
      mid_q          <= '0;
      bus.mem_addr   <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.en_KCH     <= 1'b0;
      bus.HB_reset   <= 1'b0;
      bus.fCH_ID     <= '0;
      bus.fCH_Hops   <= HOPS_INVALID;
      bus.fCH_QValue <= '0;
      bus.HB_CHlimit <= '0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only in the
      // branch that emits them, which keeps them exactly one cycle wide.
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.en_KCH   <= 1'b0;
      bus.HB_reset <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (bus.pkt_start) begin
            state        <= ST_READ;
            bus.busy     <= 1'b1;
            base_q       <= bus.pkt_base;
            bus.mem_addr <= bus.pkt_base;
            cyc          <= 4'd1;
          end
        end

        ST_READ: begin
          cyc <= cyc + 4'd1;
          if (cyc <= CYC_LAST_ADDR) begin
            bus.mem_addr <= base_q + ADDR_WIDTH'(cyc);
          end
          if (cyc == CYC_TYPE - 4'd1) begin
            state <= ST_CHECK;
          end
          if (word_valid) begin
            if (word_idx == WORD_SRC_ID) begin
              src_id_q <= word;
            end else if (word_idx == WORD_HOPS) begin
              mid_q <= word;
            end else if (word_idx == WORD_QVALUE) begin
              // Last field arrives: publish results together with done
              state    <= ST_EMIT;
              bus.done <= 1'b1;
              if (kind_q == PKT_HB) begin
                bus.HB_reset   <= 1'b1;
                bus.HB_CHlimit <= mid_q;
              end else if (mid_q != HOPS_INVALID) begin
                bus.en_KCH     <= 1'b1;
                bus.fCH_ID     <= src_id_q;
                bus.fCH_Hops   <= sat_inc(mid_q);
                bus.fCH_QValue <= word;
              end
            end
          end
        end

        ST_CHECK: begin
          cyc    <= cyc + 4'd1;
          kind_q <= rx_kind;
          if (rx_kind == PKT_UNKNOWN) begin
            // Abort: stop addressing, flag the error alongside done
            state    <= ST_FINISH;
            bus.err  <= 1'b1;
            bus.done <= 1'b1;
          end else begin
            state        <= ST_READ;
            bus.mem_addr <= base_q + ADDR_WIDTH'(cyc);
          end
        end

        ST_EMIT, ST_FINISH: begin
          // Pulse cycle; any start seen here is dropped
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ch_adv_parser.sv
// Randomized and directed bench for ch_adv_parser with a packet-level model.
module tb_ch_adv_parser;

  logic clk;
  logic nrst;

  ch_adv_parser_if bus ();

  ch_adv_parser dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packet memory: synchronous read, data one cycle after the address
  logic [7:0] mem [0:2047];
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state of the held result registers
  int m_id, m_hops, m_q, m_lim;

  task automatic model_reset();
    m_id = 0; m_hops = 16'hFFFF; m_q = 0; m_lim = 0;
  endtask

  // Packet under test, byte 0 first
  logic [7:0] pb [0:6];

  task automatic set_pkt(input logic [55:0] v);
    for (int k = 0; k < 7; k++) pb[k] = v[55 - 8*k -: 8];
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".fCH_ID"},     32'(bus.fCH_ID),     32'(m_id));
    check({tag, ".fCH_Hops"},   32'(bus.fCH_Hops),   32'(m_hops));
    check({tag, ".fCH_QValue"}, 32'(bus.fCH_QValue), 32'(m_q));
    check({tag, ".HB_CHlimit"}, 32'(bus.HB_CHlimit), 32'(m_lim));
  endtask

  // Run one parse of pb at base. restart_at/reset_at (0 = none) raise
  // pkt_start or nrst for one cycle at t+restart_at / t+reset_at.
  task automatic run_pkt(input string tag, input logic [10:0] base,
                         input int restart_at, input int reset_at);
    int  kind, id, hops, q, done_cyc;
    bit  kch, hb, aborted;
    logic [10:0] ea;
    for (int k = 0; k < 7; k++) mem[11'(int'(base) + k)] = pb[k];
    // Packet meaning from the byte layout
    kind = (pb[0] == 8'h01) ? 1 : (pb[0] == 8'h02) ? 2 : 0;
    id   = int'(pb[1]) * 256 + int'(pb[2]);
    hops = int'(pb[3]) * 256 + int'(pb[4]);
    q    = int'(pb[5]) * 256 + int'(pb[6]);
    done_cyc = (kind == 0) ? 3 : 9;
    kch  = (kind == 2) && (hops != 65535);
    hb   = (kind == 1);
    aborted = 1'b0;

    @(negedge clk);
    bus.pkt_base  = base;
    bus.pkt_start = 1'b1;          // cycle t
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);              // cycle t+c
      bus.pkt_start = (c == restart_at);
      nrst          = (c == reset_at);
      if (reset_at != 0 && c > reset_at) begin
        if (!aborted) model_reset();
        aborted = 1'b1;
      end
      if (aborted) begin
        check({tag, ".rst_busy"},     32'(bus.busy),     0);
        check({tag, ".rst_done"},     32'(bus.done),     0);
        check({tag, ".rst_en_KCH"},   32'(bus.en_KCH),   0);
        check({tag, ".rst_HB_reset"}, 32'(bus.HB_reset), 0);
        check({tag, ".rst_mem_addr"}, 32'(bus.mem_addr), 0);
      end else begin
        if (c == done_cyc) begin
          if (kch) begin
            m_id = id; m_q = q;
            m_hops = (hops + 1 > 65535) ? 65535 : hops + 1;
          end
          if (hb) m_lim = hops;
        end
        check({tag, ".busy"},     32'(bus.busy),     32'(c <= done_cyc));
        check({tag, ".done"},     32'(bus.done),     32'(c == done_cyc));
        check({tag, ".err"},      32'(bus.err),      32'(kind == 0 && c == 3));
        check({tag, ".en_KCH"},   32'(bus.en_KCH),   32'(kch && c == 9));
        check({tag, ".HB_reset"}, 32'(bus.HB_reset), 32'(hb && c == 9));
        check({tag, ".excl"},     32'(bus.en_KCH & bus.HB_reset), 0);
        if (kind != 0 && c <= 7) begin
          ea = base + 11'(c - 1);
          check({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(ea));
        end else if (kind == 0 && c <= 4) begin
          // base+1 is already out before byte 0 returns; nothing after it
          ea = base + ((c == 1) ? 11'd0 : 11'd1);
          check({tag, ".abort_addr"}, 32'(bus.mem_addr), 32'(ea));
        end
      end
      check_fields(tag);
    end
    bus.pkt_start = 1'b0;
    nrst          = 1'b0;
  endtask

  task automatic rand_pkt();
    int r;
    for (int k = 0; k < 7; k++) pb[k] = 8'($urandom_range(0, 255));
    r = $urandom_range(0, 9);
    if (r < 4)      pb[0] = 8'h02;
    else if (r < 7) pb[0] = 8'h01;
    r = $urandom_range(0, 5);
    if (r == 0) begin pb[3] = 8'hFF; pb[4] = 8'hFF; end
    if (r == 1) begin pb[3] = 8'hFF; pb[4] = 8'hFE; end
  endtask

  initial begin
    logic [10:0] base;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    bus.pkt_start = 1'b0;
    bus.pkt_base  = '0;
    nrst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.busy",     32'(bus.busy),     0);
    check("reset.done",     32'(bus.done),     0);
    check("reset.err",      32'(bus.err),      0);
    check("reset.en_KCH",   32'(bus.en_KCH),   0);
    check("reset.HB_reset", 32'(bus.HB_reset), 0);
    check("reset.mem_addr", 32'(bus.mem_addr), 0);
    check_fields("reset");
    nrst = 1'b0;
    @(negedge clk);

    // Directed cases
    set_pkt(56'h02_0005_0002_01F4);
    run_pkt("chadv_basic", 11'h010, 0, 0);
    check("chadv_basic.id_const",   32'(bus.fCH_ID),     32'h0005);
    check("chadv_basic.hops_const", 32'(bus.fCH_Hops),   32'h0003);
    check("chadv_basic.q_const",    32'(bus.fCH_QValue), 32'h01F4);

    set_pkt(56'h01_0000_000A_5A3C);
    run_pkt("hb_basic", 11'h120, 0, 0);
    check("hb_basic.limit_const", 32'(bus.HB_CHlimit), 32'd10);

    set_pkt(56'h7F_1234_5678_9ABC);
    run_pkt("unknown_7f", 11'h200, 0, 0);

    set_pkt(56'h02_0042_FFFF_0011);
    run_pkt("hops_ffff", 11'h300, 0, 0);

    set_pkt(56'h02_0043_FFFE_0022);
    run_pkt("hops_fffe", 11'h310, 0, 0);
    check("hops_fffe.hops_const", 32'(bus.fCH_Hops), 32'hFFFF);

    set_pkt(56'h02_0777_0010_0033);
    run_pkt("wrap_7fe", 11'h7FE, 0, 0);

    set_pkt(56'h02_0101_0004_0044);
    run_pkt("restart_t4", 11'h400, 4, 0);

    set_pkt(56'h02_0202_0005_0055);
    run_pkt("reset_t5", 11'h410, 0, 5);

    set_pkt(56'h01_0303_0020_0066);
    run_pkt("after_reset", 11'h420, 0, 0);

    // Randomized packets
    for (int n = 0; n < 40; n++) begin
      rand_pkt();
      base = ($urandom_range(0, 3) == 0) ? 11'(2041 + $urandom_range(0, 6))
                                         : 11'($urandom_range(0, 2047));
      run_pkt("random", base, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
